mdu_unit: RTL and testbench



---
 rtl/mdu_unit.sv | 149 ++++++++++++++
 tb/tb_mdu_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO and runs mult/div ops
// for a fixed number of busy cycles before committing the result.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   a_q, b_q;
    logic [2:0]    op_q;
    logic [31:0]   hi_q, lo_q;

    logic busy_q, op_valid, op_md, accept;

    assign busy_q   = (state_q == RUN);
    assign op_valid = (op != 3'd0) && (op != 3'd7);
    assign op_md    = (op >= OP_MULT) && (op <= OP_DIVU);
    assign accept   = start & ~flush & ~busy_q & op_valid;

    // Combinational term lets ID stall in the very cycle the op enters EX.
    assign busy = (start & ~flush & op_md & ~busy_q) | busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Arithmetic on the latched operands, consumed only at the completion edge.
    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag, b_mag, b_mag_safe, b_safe;
    logic [31:0]        q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign a_sx   = {{32{a_q[31]}}, a_q};
    assign b_sx   = {{32{b_q[31]}}, b_q};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign a_mag      = a_q[31] ? (~a_q + 32'd1) : a_q;
    assign b_mag      = b_q[31] ? (~b_q + 32'd1) : b_q;
    assign b_mag_safe = (b_q == 32'd0) ? 32'd1 : b_mag;
    assign b_safe     = (b_q == 32'd0) ? 32'd1 : b_q;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s        = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    assign q_u        = a_q / b_safe;
    assign r_u        = a_q % b_safe;

    logic        res_we;
    logic [31:0] res_hi, res_lo;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        res_we = 1'b0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT: begin
                res_we = 1'b1;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            OP_MULTU: begin
                res_we = 1'b1;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            OP_DIV: begin
                res_we = (b_q != 32'd0);
                res_hi = r_s;
                res_lo = q_s;
            end
            OP_DIVU: begin
                res_we = (b_q != 32'd0);
                res_hi = r_u;
                res_lo = q_u;
            end
            default: res_we = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_md) begin
                            a_q     <= A;
                            b_q     <= B;
                            op_q    <= op;
                            cnt_q   <= (op == OP_MULT || op == OP_MULTU)
                                       ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            state_q <= RUN;
                        end else if (op == OP_MTHI) begin
                            hi_q <= A;
                        end else if (op == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (res_we) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed test-plan cases plus random ops
// compared against a 64-bit arithmetic reference model.
module tb_mdu_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, rst_n, start, flush;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
        .op(op), .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the instruction's meaning.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            3'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                exp_lo = q[31:0]; exp_hi = r[31:0];
            end
            3'd4: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue a mult/div op; optionally try an mtlo while it runs.
    task automatic md_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit inject);
        int n;
        logic [31:0] old_hi, old_lo;
        n = (o <= 3'd2) ? MC : DC;
        old_hi = exp_hi;
        old_lo = exp_lo;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        #1 check({tag, "_busy_c0"}, 32'(busy), 32'd1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check({tag, "_busy_run"}, 32'(busy), 32'd1);
            if (k == n) begin
                check({tag, "_hi_hold"}, HI, old_hi);
                check({tag, "_lo_hold"}, LO, old_lo);
            end
            if (inject && k == 2) begin
                start = 1'b1; op = 3'd6; A = 32'h0000AAAA;
            end else begin
                start = 1'b0; op = 3'd0; A = $urandom; B = $urandom;
            end
        end
        model(o, a, b);
        @(negedge clk);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = $urandom;
        #1 check({tag, "_busy"}, 32'(busy), 32'd0);
        model(o, a, 32'd0);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; A = '0; B = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_hi", HI, 32'd0);
            check("idle_lo", LO, 32'd0);
        end

        md_op("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("mult_neg_hi_k", HI, 32'hFFFFFFFF);
        check("mult_neg_lo_k", LO, 32'hFFFFFFFA);

        md_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("multu_hi_k", HI, 32'hFFFFFFFE);
        check("multu_lo_k", LO, 32'h00000001);

        md_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_neg_lo_k", LO, 32'hFFFFFFFD);
        check("div_neg_hi_k", HI, 32'hFFFFFFFF);

        md_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_lo_k", LO, 32'h80000000);
        check("div_ovf_hi_k", HI, 32'h00000000);

        mt_op("mthi", 3'd5, 32'h00001234);
        mt_op("mtlo", 3'd6, 32'h00005678);
        md_op("divu_zero", 3'd4, 32'hDEADBEEF, 32'd0, 1'b0);
        check("divz_hi_k", HI, 32'h00001234);
        check("divz_lo_k", LO, 32'h00005678);
        md_op("div_zero", 3'd3, 32'h00000009, 32'd0, 1'b0);
        check("divsz_lo_k", LO, 32'h00005678);

        // mtlo during a running mult must be ignored.
        md_op("mult_inj", 3'd1, 32'd7, 32'd6, 1'b1);
        check("mult_inj_lo_k", LO, 32'd42);

        // start with flush: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd1; A = 32'd100; B = 32'd100;
        #1 check("flush_busy_c0", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 3'd0;
        check("flush_busy_c1", 32'(busy), 32'd0);
        check("flush_hi", HI, exp_hi);
        check("flush_lo", LO, exp_lo);

        // op 7 is reserved and must not be accepted.
        @(negedge clk);
        start = 1'b1; op = 3'd7; A = 32'h77777777;
        #1 check("op7_busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0; op = 3'd0;
        check("op7_hi", HI, exp_hi);
        check("op7_lo", LO, exp_lo);

        // Reset pulsed in cycle 3 of a div.
        mt_op("pre_rst_hi", 3'd5, 32'hCAFEF00D);
        @(negedge clk);
        start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd7;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0; op = 3'd0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DC + 2; k++) @(negedge clk);
        check("postrst_busy", 32'(busy), 32'd0);
        check("postrst_hi", HI, 32'd0);
        check("postrst_lo", LO, 32'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = {28'd0, rb[3:0]};
            if (ro >= 3'd5) mt_op("rnd_mt", ro, ra);
            else md_op("rnd_md", ro, ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
